// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-lite read scanner: default parameters,
// FSM state encoding and the word-address helper.
// Latency: n/a (package). Backpressure: n/a.
package axil_pkg;

  localparam int CNT_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TMO_CYC_DEF    = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

  // Byte address of 32-bit word idx relative to base; wraps at 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; data_o is valid whenever valid_o is high.
// Latency: a push is visible on data_o/valid_o the cycle after it is written.
// Backpressure: push while full and pop while empty are dropped; count_o lets the writer reserve space.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side;
//        pop_i/data_o/valid_o read side; count_o current occupancy.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: its contents are only observed through the
  // empty-gated read port below.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/axil_read_scan.sv
// Walks scan_cnt consecutive 32-bit words from scan_base through an AXI-lite read
// master, one request outstanding, and queues returned data in a FWFT result FIFO.
// Latency: rvalid one cycle after entering REQ; done pulse one cycle after DONE.
// Backpressure: a request is only issued when the master is ready and a FIFO slot is free.
// Ports: s_axi_aclk/s_axi_aresetn clock and async reset; scan_* control/status;
//        s_axi_cfg_* request/response to the read master; m_* result stream.
module axil_read_scan
  import axil_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TMO_CYC    = TMO_CYC_DEF
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             scan_start,
  input  logic [31:0]      scan_base,
  input  logic [CNT_W-1:0] scan_cnt,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             scan_err,
  output logic             s_axi_cfg_rvalid,
  output logic [31:0]      s_axi_cfg_raddr,
  input  logic             s_axi_cfg_rready,
  input  logic [31:0]      s_axi_cfg_rdata,
  input  logic             s_axi_cfg_rdv,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int TW  = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  // Reset asserts asynchronously but releases on a clock edge, so every flop
  // below leaves reset together.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) rst_sync_q <= 2'b00;
    else                rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  scan_state_e      state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] idx_inc;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      raddr_q, raddr_d;
  logic             fifo_push;
  logic [FCW-1:0]   fifo_cnt;

  assign idx_inc = idx_q + CNT_W'(1);

  always_ff @(posedge s_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      raddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      raddr_q  <= raddr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tmo_d     = '0;
    err_d     = err_q;
    done_d    = 1'b0;
    rvalid_d  = 1'b0;
    raddr_d   = raddr_q;
    fifo_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          base_d  = scan_base;
          cnt_d   = scan_cnt;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = (scan_cnt == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        // Issuing only with a free slot guarantees the response can be pushed.
        if (s_axi_cfg_rready && (fifo_cnt < FCW'(FIFO_DEPTH))) begin
          rvalid_d = 1'b1;
          raddr_d  = word_addr(base_q, 32'(idx_q));
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_axi_cfg_rdv) begin
          fifo_push = 1'b1;
          idx_d     = idx_inc;
          state_d   = (idx_inc == cnt_q) ? ST_DONE : ST_REQ;
        end else if (tmo_q == TW'(TMO_CYC - 2)) begin
          // Abort on the edge where the counter would step to TMO_CYC-1.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sync_fifo_fwft #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (s_axi_aclk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .data_i  (s_axi_cfg_rdata),
    .pop_i   (m_ready),
    .data_o  (m_data),
    .valid_o (m_valid),
    .count_o (fifo_cnt)
  );

  assign scan_busy        = (state_q != ST_IDLE);
  assign scan_done        = done_q;
  assign scan_err         = err_q;
  assign s_axi_cfg_rvalid = rvalid_q;
  assign s_axi_cfg_raddr  = raddr_q;

endmodule

// File: tb/tb_axil_read_scan.sv
// Self-checking bench for axil_read_scan with a randomized read-master responder,
// randomized ready patterns and a queue-based reference of addresses and data.
// Latency/backpressure: exercised through FIFO-full stalls and timeout aborts.
module tb_axil_read_scan;

  logic        clk = 1'b0;
  logic        s_axi_aresetn = 1'b1;
  logic        scan_start = 1'b0;
  logic [31:0] scan_base = '0;
  logic [7:0]  scan_cnt = '0;
  logic        scan_busy, scan_done, scan_err;
  logic        s_axi_cfg_rvalid;
  logic [31:0] s_axi_cfg_raddr;
  logic        s_axi_cfg_rready = 1'b0;
  logic [31:0] s_axi_cfg_rdata = '0;
  logic        s_axi_cfg_rdv = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] req_q[$];
  int          req_cyc[$];
  logic [31:0] pop_q[$];
  logic [31:0] data_exp[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;

  bit resp_en = 1'b1;
  bit fixed_data = 1'b0;
  int resp_n = 0;
  int resp_min = 1;
  int resp_max = 3;
  int rrdy_mode = 1;   // 0 low, 1 high, 2 random
  int mrdy_mode = 1;

  axil_read_scan #(
    .CNT_W      (8),
    .FIFO_DEPTH (4),
    .TMO_CYC    (16)
  ) dut (
    .s_axi_aclk       (clk),
    .s_axi_aresetn    (s_axi_aresetn),
    .scan_start       (scan_start),
    .scan_base        (scan_base),
    .scan_cnt         (scan_cnt),
    .scan_busy        (scan_busy),
    .scan_done        (scan_done),
    .scan_err         (scan_err),
    .s_axi_cfg_rvalid (s_axi_cfg_rvalid),
    .s_axi_cfg_raddr  (s_axi_cfg_raddr),
    .s_axi_cfg_rready (s_axi_cfg_rready),
    .s_axi_cfg_rdata  (s_axi_cfg_rdata),
    .s_axi_cfg_rdv    (s_axi_cfg_rdv),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Ready drivers: single writer for rready and m_ready.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rrdy_mode)
        0:       s_axi_cfg_rready = 1'b0;
        1:       s_axi_cfg_rready = 1'b1;
        default: s_axi_cfg_rready = ($urandom_range(3, 0) != 0);
      endcase
      case (mrdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(1, 0) != 0);
      endcase
    end
  end

  // Read master model: answers each request after a random delay.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (s_axi_cfg_rvalid && resp_en && s_axi_aresetn) begin
        d = $urandom_range(resp_max, resp_min);
        repeat (d) tick();
        s_axi_cfg_rdv   = 1'b1;
        s_axi_cfg_rdata = fixed_data ? (32'hA0 + 32'(resp_n)) : $urandom;
        resp_n++;
        data_exp.push_back(s_axi_cfg_rdata);
        tick();
        s_axi_cfg_rdv = 1'b0;
      end
    end
  end

  // Observation: requests, pops and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (s_axi_aresetn) begin
      if (s_axi_cfg_rvalid) begin
        req_q.push_back(s_axi_cfg_raddr);
        req_cyc.push_back(cyc);
      end
      if (m_valid && m_ready) pop_q.push_back(m_data);
      if (scan_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  task automatic clr();
    req_q.delete();
    req_cyc.delete();
    pop_q.delete();
    data_exp.delete();
    done_cnt = 0;
    resp_n = 0;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [7:0] c);
    scan_base  = b;
    scan_cnt   = c;
    scan_start = 1'b1;
    start_cyc  = cyc;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (m_valid === 1'b0) break;
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    #1 s_axi_aresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({scan_busy, scan_done, scan_err, s_axi_cfg_rvalid, m_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {scan_busy, scan_done, scan_err, s_axi_cfg_rvalid, m_valid});
    end
    checks++;
    if (s_axi_cfg_raddr !== 32'h0 || m_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got raddr=%h m_data=%h exp 0", s_axi_cfg_raddr, m_data);
    end
    s_axi_aresetn = 1'b1;
    repeat (4) tick();
    checks++;
    if (scan_busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got busy=%b m_valid=%b exp 0 0", scan_busy, m_valid);
    end
  endtask

  task automatic test_normal();
    bit ok;
    logic [31:0] got;
    clr();
    resp_en = 1; fixed_data = 1; resp_min = 1; resp_max = 3;
    rrdy_mode = 1; mrdy_mode = 1;
    do_start(32'h1000, 8'd3);
    wait_done(300, ok);
    drain();
    checks++;
    if (!ok) begin failures++; $display("FAIL normal_done got=timeout exp=done"); end
    checks++;
    if (req_q.size() != 3) begin
      failures++; $display("FAIL normal_nreq got=%0d exp=3", req_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < req_q.size()) ? req_q[i] : 32'hxxxxxxxx;
      checks++;
      if (got !== 32'h1000 + 32'(i) * 4) begin
        failures++; $display("FAIL normal_addr%0d got=%h exp=%h", i, got, 32'h1000 + 32'(i) * 4);
      end
      got = (i < pop_q.size()) ? pop_q[i] : 32'hxxxxxxxx;
      checks++;
      if (got !== 32'hA0 + 32'(i)) begin
        failures++; $display("FAIL normal_data%0d got=%h exp=%h", i, got, 32'hA0 + 32'(i));
      end
    end
    checks++;
    if (req_cyc.size() == 0 || req_cyc[0] - start_cyc != 2) begin
      failures++;
      $display("FAIL normal_req_latency got=%0d exp=2",
               (req_cyc.size() == 0) ? -1 : req_cyc[0] - start_cyc);
    end
    checks++;
    if (done_cnt != 1 || scan_err !== 1'b0 || scan_busy !== 1'b0) begin
      failures++;
      $display("FAIL normal_status got done=%0d err=%b busy=%b exp 1 0 0", done_cnt, scan_err, scan_busy);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] b, got;
    logic [7:0]  c;
    for (int s = 0; s < 6; s++) begin
      clr();
      resp_en = 1; fixed_data = 0; resp_min = 1; resp_max = 4;
      rrdy_mode = 2; mrdy_mode = 2;
      b = $urandom;
      c = 8'($urandom_range(8, 1));
      do_start(b, c);
      wait_done(400, ok);
      mrdy_mode = 1;
      drain();
      checks++;
      if (!ok || done_cnt != 1 || scan_err !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_status got ok=%0d done=%0d err=%b exp 1 1 0", s, ok, done_cnt, scan_err);
      end
      checks++;
      if (req_q.size() != int'(c) || pop_q.size() != int'(c)) begin
        failures++;
        $display("FAIL rand%0d_count got req=%0d pop=%0d exp=%0d", s, req_q.size(), pop_q.size(), c);
      end
      for (int i = 0; i < int'(c); i++) begin
        got = (i < req_q.size()) ? req_q[i] : 32'hxxxxxxxx;
        checks++;
        if (got !== b + 32'(i) * 4) begin
          failures++; $display("FAIL rand%0d_addr%0d got=%h exp=%h", s, i, got, b + 32'(i) * 4);
        end
        got = (i < pop_q.size()) ? pop_q[i] : 32'hxxxxxxxx;
        checks++;
        if (i >= data_exp.size() || got !== data_exp[i]) begin
          failures++;
          $display("FAIL rand%0d_data%0d got=%h exp=%h", s, i, got,
                   (i < data_exp.size()) ? data_exp[i] : 32'hxxxxxxxx);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] got;
    clr();
    resp_en = 1; fixed_data = 0; resp_min = 1; resp_max = 2;
    rrdy_mode = 1; mrdy_mode = 0;
    do_start(32'h0800_0000, 8'd6);
    repeat (60) tick();
    checks++;
    if (req_q.size() != 4 || pop_q.size() != 0) begin
      failures++; $display("FAIL bp_stall got req=%0d pop=%0d exp 4 0", req_q.size(), pop_q.size());
    end
    checks++;
    if (scan_busy !== 1'b1 || m_valid !== 1'b1 || data_exp.size() == 0 || m_data !== data_exp[0]) begin
      failures++;
      $display("FAIL bp_head got busy=%b m_valid=%b m_data=%h exp 1 1 %h", scan_busy, m_valid, m_data,
               (data_exp.size() != 0) ? data_exp[0] : 32'hxxxxxxxx);
    end
    mrdy_mode = 1;
    wait_done(300, ok);
    drain();
    checks++;
    if (!ok || req_q.size() != 6 || pop_q.size() != 6) begin
      failures++;
      $display("FAIL bp_finish got ok=%0d req=%0d pop=%0d exp 1 6 6", ok, req_q.size(), pop_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < pop_q.size()) ? pop_q[i] : 32'hxxxxxxxx;
      checks++;
      if (i >= data_exp.size() || got !== data_exp[i]) begin
        failures++; $display("FAIL bp_data%0d got=%h", i, got);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clr();
    resp_en = 0; rrdy_mode = 1; mrdy_mode = 1;
    do_start($urandom, 8'd3);
    wait_done(100, ok);
    repeat (5) tick();
    checks++;
    if (!ok || req_cyc.size() != 1 || done_cyc - req_cyc[0] != 16) begin
      failures++;
      $display("FAIL tmo_timing got ok=%0d req=%0d delta=%0d exp 1 1 16", ok, req_cyc.size(),
               (req_cyc.size() != 0) ? done_cyc - req_cyc[0] : -1);
    end
    checks++;
    if (scan_err !== 1'b1 || m_valid !== 1'b0 || scan_busy !== 1'b0 || done_cnt != 1) begin
      failures++;
      $display("FAIL tmo_status got err=%b m_valid=%b busy=%b done=%0d exp 1 0 0 1",
               scan_err, m_valid, scan_busy, done_cnt);
    end
    resp_en = 1;
  endtask

  task automatic test_edges();
    bit ok;
    // Zero-length scan; also clears the sticky error from the previous test.
    clr();
    resp_min = 1; resp_max = 3;
    do_start(32'h2000, 8'd0);
    wait_done(20, ok);
    repeat (3) tick();
    checks++;
    if (!ok || done_cyc - start_cyc != 2 || req_q.size() != 0 || scan_err !== 1'b0) begin
      failures++;
      $display("FAIL edge_cnt0 got ok=%0d delta=%0d req=%0d err=%b exp 1 2 0 0",
               ok, done_cyc - start_cyc, req_q.size(), scan_err);
    end
    // Address wrap past 2^32.
    clr();
    do_start(32'hFFFF_FFFC, 8'd2);
    wait_done(100, ok);
    drain();
    checks++;
    if (req_q.size() != 2 || req_q[0] !== 32'hFFFF_FFFC || req_q[1] !== 32'h0) begin
      failures++;
      $display("FAIL edge_wrap got n=%0d a1=%h exp 2 00000000", req_q.size(),
               (req_q.size() > 1) ? req_q[1] : 32'hxxxxxxxx);
    end
    // Start while busy is ignored.
    clr();
    resp_min = 4; resp_max = 4;
    do_start(32'h3000, 8'd2);
    repeat (3) tick();
    scan_base = 32'h5000; scan_cnt = 8'd5; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    wait_done(100, ok);
    repeat (10) tick();
    checks++;
    if (!ok || done_cnt != 1 || req_q.size() != 2 || scan_busy !== 1'b0) begin
      failures++;
      $display("FAIL edge_busy_start got ok=%0d done=%0d req=%0d busy=%b exp 1 1 2 0",
               ok, done_cnt, req_q.size(), scan_busy);
    end
    checks++;
    if (req_q.size() < 2 || req_q[1] !== 32'h3004) begin
      failures++;
      $display("FAIL edge_busy_addr got=%h exp=00003004", (req_q.size() > 1) ? req_q[1] : 32'hxxxxxxxx);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clr();
    resp_en = 1; fixed_data = 0; resp_min = 3; resp_max = 4;
    rrdy_mode = 1; mrdy_mode = 0;
    do_start(32'h0000_9000, 8'd4);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (req_q.size() == 3) begin seen = 1'b1; break; end
    end
    #1;
    checks++;
    if (!seen || m_valid !== 1'b1 || scan_busy !== 1'b1) begin
      failures++;
      $display("FAIL rmid_setup got seen=%0d m_valid=%b busy=%b exp 1 1 1", seen, m_valid, scan_busy);
    end
    s_axi_aresetn = 1'b0;
    #1;
    checks++;
    if ({scan_busy, scan_done, scan_err, s_axi_cfg_rvalid, m_valid} !== 5'b0 ||
        s_axi_cfg_raddr !== 32'h0 || m_data !== 32'h0) begin
      failures++;
      $display("FAIL rmid_async got flags=%b raddr=%h m_data=%h exp 00000 0 0",
               {scan_busy, scan_done, scan_err, s_axi_cfg_rvalid, m_valid}, s_axi_cfg_raddr, m_data);
    end
    repeat (3) tick();
    s_axi_aresetn = 1'b1;
    repeat (8) tick();
    checks++;
    if (m_valid !== 1'b0 || scan_busy !== 1'b0) begin
      failures++; $display("FAIL rmid_stray_rdv got m_valid=%b busy=%b exp 0 0", m_valid, scan_busy);
    end
    clr();
    resp_min = 1; resp_max = 3; mrdy_mode = 1;
    do_start(32'h0000_4000, 8'd1);
    wait_done(100, ok);
    drain();
    checks++;
    if (!ok || req_q.size() != 1 || req_q[0] !== 32'h4000 || scan_err !== 1'b0) begin
      failures++;
      $display("FAIL rmid_rescan got ok=%0d req=%0d err=%b exp 1 1 0", ok, req_q.size(), scan_err);
    end
    checks++;
    if (pop_q.size() != 1 || data_exp.size() != 1 || pop_q[0] !== data_exp[0]) begin
      failures++;
      $display("FAIL rmid_rescan_data got n=%0d data=%h", pop_q.size(),
               (pop_q.size() != 0) ? pop_q[0] : 32'hxxxxxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_random();
    test_backpressure();
    test_timeout();
    test_edges();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
